// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared time width, reset defaults and edge saturation helper
package pulse_pkg;
   localparam int W = 32;

   typedef logic [W-1:0] time_t;
   typedef logic [W:0]   edge_t;

   localparam time_t DEF_PER  = time_t'(201000);
   localparam time_t DEF_P1   = time_t'(30);
   localparam time_t DEF_DEL  = time_t'(200);
   localparam time_t DEF_P2   = time_t'(30);
   localparam time_t DEF_BOFF = time_t'(100);
   localparam time_t MIN_PER  = time_t'(2);

   // Clamp an edge to the period end so windows truncate instead of wrapping.
   function automatic edge_t sat_edge(input edge_t e, input edge_t lim);
      return (e >= lim) ? lim : e;
   endfunction
endpackage

// File: rtl/pulse_window.sv
// rtl/pulse_window.sv - half-open [start, stop) window flag on the period counter
module pulse_window
   import pulse_pkg::*;
(
   input  edge_t cnt,
   input  edge_t start,
   input  edge_t stop,
   output logic  in_win
);
   assign in_win = (start < stop) && (cnt >= start) && (cnt < stop);
endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - two-pulse echo timing engine; receiver block gate built only when PULSE_SEQUENCER_BLOCK_EN is defined
module pulse_sequencer #(
   parameter pulse_pkg::time_t DEF_PER  = pulse_pkg::DEF_PER,
   parameter pulse_pkg::time_t DEF_P1   = pulse_pkg::DEF_P1,
   parameter pulse_pkg::time_t DEF_DEL  = pulse_pkg::DEF_DEL,
   parameter pulse_pkg::time_t DEF_P2   = pulse_pkg::DEF_P2,
   parameter pulse_pkg::time_t DEF_BOFF = pulse_pkg::DEF_BOFF,
   parameter pulse_pkg::time_t MIN_PER  = pulse_pkg::MIN_PER
) (
   input  logic             clk,
   input  logic             resetn,
   input  pulse_pkg::time_t per,
   input  pulse_pkg::time_t p1wid,
   input  pulse_pkg::time_t del,
   input  pulse_pkg::time_t p2wid,
   input  pulse_pkg::time_t p_bl_off,
   input  logic             pu,
   input  logic             bl,
   output logic             pulse,
   output logic             sync,
   output logic             blk,
   output logic             cyc_start
);
   import pulse_pkg::*;

   localparam edge_t E_ZERO = '0;
   localparam edge_t E_ONE  = edge_t'(1);

   time_t cnt;
   time_t per_s;
   time_t p1_s;
   time_t del_s;
   time_t p2_s;
   logic  pu_s;

   time_t per_in;
   logic  wrap;
   edge_t lim;
   edge_t cnt_x;
   edge_t e1;
   edge_t s2;
   edge_t e2_raw;
   edge_t e2;
   logic  sync_hit;
   logic  p1_win;
   logic  p2_win;

   assign per_in = (per < MIN_PER) ? MIN_PER : per;
   assign wrap   = (cnt == per_s - time_t'(1));
   assign lim    = {1'b0, per_s};
   assign cnt_x  = {1'b0, cnt};

   // Each edge is saturated before the next add, so W+1 bits never overflow.
   assign e1     = sat_edge({1'b0, p1_s}, lim);
   assign s2     = sat_edge(e1 + {1'b0, del_s}, lim);
   assign e2_raw = s2 + {1'b0, p2_s};
   assign e2     = sat_edge(e2_raw, lim);

   // sync only for a p2 that ends inside the period; a truncated p2 has no falling edge.
   assign sync_hit = (cnt_x == e2_raw - E_ONE) && (p2_s != '0) && (e2_raw <= lim);

   pulse_window u_p1 (.cnt(cnt_x), .start(E_ZERO), .stop(e1), .in_win(p1_win));
   pulse_window u_p2 (.cnt(cnt_x), .start(s2),     .stop(e2), .in_win(p2_win));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         per_s     <= DEF_PER;
         p1_s      <= DEF_P1;
         del_s     <= DEF_DEL;
         p2_s      <= DEF_P2;
         pu_s      <= 1'b1;
         pulse     <= 1'b0;
         sync      <= 1'b0;
         cyc_start <= 1'b0;
      end else begin
         if (wrap) begin
            cnt   <= '0;
            per_s <= per_in;
            p1_s  <= p1wid;
            del_s <= del;
            p2_s  <= p2wid;
            pu_s  <= pu;
         end else begin
            cnt <= cnt + time_t'(1);
         end
         pulse     <= pu_s & (p1_win | p2_win);
         sync      <= sync_hit;
         cyc_start <= (cnt == '0);
      end
   end

`ifdef PULSE_SEQUENCER_BLOCK_EN
   time_t boff_s;
   logic  bl_s;
   logic  blk_q;
   logic  blk_win;
   edge_t eb;

   assign eb = sat_edge(e2 + {1'b0, boff_s}, lim);

   pulse_window u_blk (.cnt(cnt_x), .start(E_ZERO), .stop(eb), .in_win(blk_win));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         boff_s <= DEF_BOFF;
         bl_s   <= 1'b1;
         blk_q  <= 1'b0;
      end else begin
         if (wrap) begin
            boff_s <= p_bl_off;
            bl_s   <= bl;
         end
         blk_q <= bl_s & blk_win;
      end
   end

   assign blk = blk_q;
`else
   logic unused_blk;
   assign unused_blk = ^{p_bl_off, bl, DEF_BOFF};
   assign blk        = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - table, hand-sequence and random checks of pulse_sequencer against a period-level model
module tb_pulse_sequencer;
   import pulse_pkg::*;

   localparam longint TB_DEF_PER = 400;
`ifdef PULSE_SEQUENCER_BLOCK_EN
   localparam bit BLK_ON = 1'b1;
`else
   localparam bit BLK_ON = 1'b0;
`endif
   localparam logic [3:0] MASK = {2'b11, BLK_ON, 1'b1};

   typedef struct {
      longint per, p1, del, p2, boff;
      bit     pu, bl;
   } cfg_t;

   typedef struct {
      cfg_t       c;
      int         k;
      logic [3:0] exp;
   } vec_t;

   logic  clk = 1'b0;
   logic  resetn = 1'b0;
   time_t per, p1wid, del, p2wid, p_bl_off;
   logic  pu, bl;
   logic  pulse, sync, blk, cyc_start;

   int checks = 0;
   int errors = 0;

   cfg_t       m_cfg;
   longint     m_k;
   logic [3:0] m_exp;
   cfg_t       def_cfg;
   vec_t       tbl[$];

   pulse_sequencer #(.DEF_PER(time_t'(TB_DEF_PER))) dut (
      .clk(clk), .resetn(resetn), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
      .p_bl_off(p_bl_off), .pu(pu), .bl(bl), .pulse(pulse), .sync(sync), .blk(blk),
      .cyc_start(cyc_start)
   );

   always #5 clk = ~clk;

   function automatic cfg_t mkc(longint pr, longint a, longint d, longint b, longint o, bit u, bit g);
      cfg_t c;
      c.per = pr; c.p1 = a; c.del = d; c.p2 = b; c.boff = o; c.pu = u; c.bl = g;
      return c;
   endfunction

   function automatic longint lmin(longint a, longint b);
      return (a < b) ? a : b;
   endfunction

   function automatic longint eff_per(cfg_t c);
      return (c.per < 2) ? 2 : c.per;
   endfunction

   // Output vector {pulse, sync, blk, cyc_start} for period position k.
   function automatic logic [3:0] ref_out(cfg_t c, longint k);
      longint pe, p2_lo, p2_hi, blk_hi, end2;
      logic p, s, b;
      pe     = eff_per(c);
      end2   = c.p1 + c.del + c.p2;
      p2_lo  = lmin(c.p1 + c.del, pe);
      p2_hi  = lmin(end2, pe);
      blk_hi = lmin(end2 + c.boff, pe);
      p = c.pu && ((k < lmin(c.p1, pe)) || (k >= p2_lo && k < p2_hi));
      s = (c.p2 != 0) && (end2 <= pe) && (k == end2 - 1);
      b = BLK_ON && c.bl && (k < blk_hi);
      return {p, s, b, k == 0};
   endfunction

   function automatic cfg_t cur_inputs();
      return mkc(longint'(per), longint'(p1wid), longint'(del), longint'(p2wid),
                 longint'(p_bl_off), pu, bl);
   endfunction

   task automatic set_cfg(cfg_t c);
      per = time_t'(c.per); p1wid = time_t'(c.p1); del = time_t'(c.del);
      p2wid = time_t'(c.p2); p_bl_off = time_t'(c.boff); pu = c.pu; bl = c.bl;
   endtask

   task automatic compare(string name, logic [3:0] got, logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got {pulse,sync,blk,cyc}=%b want=%b", name, $time, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (resetn) begin
         m_exp = ref_out(m_cfg, m_k);
         if (m_k == eff_per(m_cfg) - 1) begin
            m_k   = 0;
            m_cfg = cur_inputs();
         end else begin
            m_k++;
         end
      end else begin
         m_exp = '0;
         m_k   = 0;
         m_cfg = def_cfg;
      end
      #1;
      compare("model", {pulse, sync, blk, cyc_start}, m_exp);
   endtask

   // Leaves the bench one cycle into a period whose settings were loaded after the call.
   task automatic sync_period();
      bit found = 1'b0;
      tick();
      for (int i = 0; i < 600 && !found; i++) begin
         tick();
         if (cyc_start === 1'b1) found = 1'b1;
      end
      compare("period_start", {3'b000, found}, 4'b0001);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      m_k    = 0;
      m_cfg  = def_cfg;
      #1;
      compare("reset_async", {pulse, sync, blk, cyc_start}, 4'b0000);
      tick();
      resetn = 1'b1;
   endtask

   function automatic cfg_t rand_cfg();
      return mkc($urandom_range(0, 40), $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
   endfunction

   initial begin
      cfg_t a_cfg, pu0, t4, t5a, t5b, mrg, z1, bnd;
      def_cfg = mkc(TB_DEF_PER, 30, 200, 30, 100, 1'b1, 1'b1);
      a_cfg = mkc(100, 3, 10, 5, 4, 1'b1, 1'b1);
      pu0   = mkc(100, 3, 10, 5, 4, 1'b0, 1'b1);
      t4    = mkc(20, 5, 10, 10, 4, 1'b1, 1'b1);
      t5a   = mkc(1, 0, 0, 4, 0, 1'b1, 1'b1);
      t5b   = mkc(1, 0, 5, 1, 0, 1'b1, 1'b1);
      mrg   = mkc(50, 4, 0, 3, 0, 1'b1, 1'b0);
      z1    = mkc(30, 0, 2, 3, 1, 1'b1, 1'b1);
      bnd   = mkc(10, 2, 3, 5, 0, 1'b1, 1'b1);

      tbl.push_back('{a_cfg, 1, 4'b1011});  tbl.push_back('{a_cfg, 3, 4'b1010});
      tbl.push_back('{a_cfg, 4, 4'b0010});  tbl.push_back('{a_cfg, 14, 4'b1010});
      tbl.push_back('{a_cfg, 18, 4'b1110}); tbl.push_back('{a_cfg, 19, 4'b0010});
      tbl.push_back('{a_cfg, 22, 4'b0010}); tbl.push_back('{a_cfg, 23, 4'b0000});
      tbl.push_back('{a_cfg, 100, 4'b0000});
      tbl.push_back('{pu0, 3, 4'b0010});    tbl.push_back('{pu0, 18, 4'b0110});
      tbl.push_back('{t4, 1, 4'b1011});     tbl.push_back('{t4, 5, 4'b1010});
      tbl.push_back('{t4, 6, 4'b0010});     tbl.push_back('{t4, 16, 4'b1010});
      tbl.push_back('{t4, 20, 4'b1010});
      tbl.push_back('{t5a, 1, 4'b1011});    tbl.push_back('{t5a, 2, 4'b1010});
      tbl.push_back('{t5a, 3, 4'b1011});
      tbl.push_back('{t5b, 1, 4'b0011});    tbl.push_back('{t5b, 2, 4'b0010});
      tbl.push_back('{mrg, 1, 4'b1001});    tbl.push_back('{mrg, 5, 4'b1000});
      tbl.push_back('{mrg, 7, 4'b1100});    tbl.push_back('{mrg, 8, 4'b0000});
      tbl.push_back('{z1, 1, 4'b0011});     tbl.push_back('{z1, 2, 4'b0010});
      tbl.push_back('{z1, 3, 4'b1010});     tbl.push_back('{z1, 5, 4'b1110});
      tbl.push_back('{z1, 6, 4'b0010});     tbl.push_back('{z1, 7, 4'b0000});
      tbl.push_back('{bnd, 1, 4'b1011});    tbl.push_back('{bnd, 3, 4'b0010});
      tbl.push_back('{bnd, 6, 4'b1010});    tbl.push_back('{bnd, 10, 4'b1110});

      resetn = 1'b0;
      m_k    = 0;
      m_cfg  = def_cfg;
      set_cfg(a_cfg);
      #2;
      compare("reset_state", {pulse, sync, blk, cyc_start}, 4'b0000);
      tick();
      tick();
      resetn = 1'b1;

      foreach (tbl[i]) begin
         set_cfg(tbl[i].c);
         sync_period();
         for (int j = 1; j < tbl[i].k; j++) tick();
         compare($sformatf("vec%0d_k%0d", i, tbl[i].k), {pulse, sync, blk, cyc_start},
                 tbl[i].exp & MASK);
      end

      // Mid-period change is held off until the next wrap.
      set_cfg(a_cfg);
      sync_period();
      for (int j = 1; j < 6; j++) tick();
      del = time_t'(20);
      for (int j = 6; j < 14; j++) tick();
      compare("late_del_cur_p2", {pulse, sync, blk, cyc_start}, 4'b1010 & MASK);
      sync_period();
      for (int j = 1; j < 23; j++) tick();
      compare("late_del_k23", {pulse, sync, blk, cyc_start}, 4'b0010 & MASK);
      tick();
      compare("late_del_k24", {pulse, sync, blk, cyc_start}, 4'b1010 & MASK);
      for (int j = 24; j < 28; j++) tick();
      compare("late_del_k28", {pulse, sync, blk, cyc_start}, 4'b1110 & MASK);

      // Reset in the middle of p2, then a default-valued period.
      set_cfg(a_cfg);
      sync_period();
      for (int j = 1; j < 16; j++) tick();
      compare("pre_reset_p2", {pulse, sync, blk, cyc_start}, 4'b1010 & MASK);
      do_reset();
      for (int k = 1; k <= 401; k++) begin
         tick();
         if (k == 1)   compare("def_k1",   {pulse, sync, blk, cyc_start}, 4'b1011 & MASK);
         if (k == 30)  compare("def_k30",  {pulse, sync, blk, cyc_start}, 4'b1010 & MASK);
         if (k == 31)  compare("def_k31",  {pulse, sync, blk, cyc_start}, 4'b0010 & MASK);
         if (k == 231) compare("def_k231", {pulse, sync, blk, cyc_start}, 4'b1010 & MASK);
         if (k == 260) compare("def_k260", {pulse, sync, blk, cyc_start}, 4'b1110 & MASK);
         if (k == 361) compare("def_k361", {pulse, sync, blk, cyc_start}, 4'b0000);
         if (k == 401) compare("def_k401", {pulse, sync, blk, cyc_start}, 4'b1011 & MASK);
      end

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) set_cfg(rand_cfg());
         if ($urandom_range(0, 1499) == 0) do_reset();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
